// File: rtl/rtc_calendar_core.sv
// Second-through-year timekeeping core with tick prescaler, Gregorian leap rules,
// field-wise manual setting with day clamping, and an hour:minute alarm.
module rtc_calendar_core #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int YEAR_W     = 14,
    parameter int YEAR_MAX   = 9999,
    parameter int YEAR_RESET = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              set_mode,
    input  logic [2:0]        sel,
    input  logic              inc,
    input  logic              dec,
    input  logic              alarm_en,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_minute,
    output logic [5:0]        second,
    output logic [5:0]        minute,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              sec_pulse,
    output logic              alarm_hit,
    output logic              leap
);
    localparam int                PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [YEAR_W-1:0] YMAX     = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] YRST     = YEAR_W'(YEAR_RESET);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int unsigned yi;
        yi = 32'(y);
        return ((yi % 4 == 0) && (yi % 100 != 0)) || (yi % 400 == 0);
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return lp ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [5:0]        sec_q, sec_d, min_q, min_d;
    logic [4:0]        hour_q, hour_d, day_q, day_d;
    logic [3:0]        mon_q, mon_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              pulse_q, pulse_d, alarm_q, alarm_d;
    logic              tick, leap_cur, alarm_ok;
    logic [4:0]        dim_cur, dim_mon_step, dim_yr_step;
    logic [3:0]        mon_step;
    logic [YEAR_W-1:0] yr_step;

    assign leap_cur = is_leap(year_q);
    assign dim_cur  = days_in(mon_q, leap_cur);
    assign alarm_ok = (alarm_hour < 5'd24) && (alarm_minute < 6'd60);

    // Month/year edit candidates, so the day clamp sees the post-edit month length.
    assign mon_step = inc ? ((mon_q == 4'd12) ? 4'd1 : mon_q + 4'd1)
                          : ((mon_q <= 4'd1) ? 4'd12 : mon_q - 4'd1);
    assign yr_step  = inc ? ((year_q >= YMAX) ? '0 : year_q + 1'b1)
                          : ((year_q == '0) ? YMAX : year_q - 1'b1);
    assign dim_mon_step = days_in(mon_step, leap_cur);
    assign dim_yr_step  = days_in(mon_q, is_leap(yr_step));

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        mon_d   = mon_q;
        year_d  = year_q;
        tick    = 1'b0;
        if (set_mode) begin
            presc_d = '0;
            if (inc ^ dec) begin
                case (sel)
                    3'd0: sec_d  = inc ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                       : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                    3'd1: min_d  = inc ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                       : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                    3'd2: hour_d = inc ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1)
                                       : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
                    3'd3: day_d  = inc ? ((day_q >= dim_cur) ? 5'd1 : day_q + 5'd1)
                                       : ((day_q <= 5'd1) ? dim_cur : day_q - 5'd1);
                    3'd4: begin
                        mon_d = mon_step;
                        if (day_q > dim_mon_step) day_d = dim_mon_step;
                    end
                    3'd5: begin
                        year_d = yr_step;
                        if (day_q > dim_yr_step) day_d = dim_yr_step;
                    end
                    default: ;
                endcase
            end
        end else if (run_en) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        if (hour_q == 5'd23) begin
                            hour_d = 5'd0;
                            if (day_q >= dim_cur) begin
                                day_d = 5'd1;
                                if (mon_q == 4'd12) begin
                                    mon_d  = 4'd1;
                                    year_d = (year_q >= YMAX) ? '0 : year_q + 1'b1;
                                end else begin
                                    mon_d = mon_q + 4'd1;
                                end
                            end else begin
                                day_d = day_q + 5'd1;
                            end
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        pulse_d = tick;
        alarm_d = tick && alarm_en && alarm_ok && (hour_d == alarm_hour) &&
                  (min_d == alarm_minute) && (sec_d == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            day_q   <= 5'd1;
            mon_q   <= 4'd1;
            year_q  <= YRST;
            pulse_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            year_q  <= year_d;
            pulse_q <= pulse_d;
            alarm_q <= alarm_d;
        end
    end

    assign second    = sec_q;
    assign minute    = min_q;
    assign hour      = hour_q;
    assign day       = day_q;
    assign month     = mon_q;
    assign year      = year_q;
    assign sec_pulse = pulse_q;
    assign alarm_hit = alarm_q;
    assign leap      = leap_cur;
endmodule

// File: tb/tb_rtc_calendar_core.sv
// Scoreboard bench for rtc_calendar_core with a 4-cycle second.
module tb_rtc_calendar_core;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, run_en = 1'b0, set_mode = 1'b0, inc = 1'b0, dec = 1'b0;
    logic        alarm_en = 1'b0;
    logic [2:0]  sel = 3'd7;
    logic [4:0]  alarm_hour = 5'd0;
    logic [5:0]  alarm_minute = 6'd0;
    logic [5:0]  second, minute;
    logic [4:0]  hour, day;
    logic [3:0]  month;
    logic [13:0] year;
    logic        sec_pulse, alarm_hit, leap;

    int          checks = 0;
    int          passes = 0;
    int          alarm_cnt = 0;
    logic [39:0] sb[$];
    logic [39:0] exp_t;

    rtc_calendar_core #(.TICK_DIV(TD), .YEAR_W(14), .YEAR_MAX(9999), .YEAR_RESET(2000)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .set_mode(set_mode), .sel(sel),
        .inc(inc), .dec(dec), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
        .alarm_minute(alarm_minute), .second(second), .minute(minute), .hour(hour),
        .day(day), .month(month), .year(year), .sec_pulse(sec_pulse),
        .alarm_hit(alarm_hit), .leap(leap)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (alarm_hit === 1'b1) alarm_cnt++;

    function automatic logic [39:0] mk(int y, int mo, int d, int h, int mi, int s);
        return {14'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction

    function automatic logic [39:0] now_t();
        return {year, month, day, hour, minute, second};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] s, input bit up, input int n);
        if (n > 0) begin
            sel = s; inc = up; dec = !up;
            step(n);
            inc = 1'b0; dec = 1'b0;
        end
    endtask

    // Starts from the reset date and walks each field into place in set mode.
    task automatic set_time(input int y, input int mo, input int d, input int h, input int mi, input int s);
        int up_n, dn_n;
        rst = 1'b1; set_mode = 1'b1; run_en = 1'b0; inc = 1'b0; dec = 1'b0;
        step(1);
        rst = 1'b0;
        up_n = (y >= 2000) ? y - 2000 : 100000;
        dn_n = (y >= 2000) ? 2001 + (9999 - y) : 2000 - y;
        if (up_n <= dn_n) pulse(3'd5, 1'b1, up_n); else pulse(3'd5, 1'b0, dn_n);
        pulse(3'd4, 1'b1, mo - 1);
        pulse(3'd3, 1'b1, d - 1);
        pulse(3'd2, 1'b1, h);
        pulse(3'd1, 1'b1, mi);
        pulse(3'd0, 1'b1, s);
    endtask

    task automatic run_to_pulse(output int n);
        n = 0;
        while (sec_pulse !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
    endtask

    task automatic do_tick(output int n);
        set_mode = 1'b0; run_en = 1'b1;
        run_to_pulse(n);
        run_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_en = 1'b0; set_mode = 1'b0;
        step(2);
        sb.push_back(mk(2000, 1, 1, 0, 0, 0));
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL reset_time: got %h want %h", now_t(), exp_t); else passes++;
        checks++;
        if (sec_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", sec_pulse); else passes++;
        checks++;
        if (alarm_hit !== 1'b0) $display("FAIL reset_alarm: got %b want 0", alarm_hit); else passes++;
        checks++;
        if (leap !== 1'b1) $display("FAIL reset_leap2000: got %b want 1", leap); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        int n = 0, bad = 0, last = 0;
        run_en = 1'b1;
        sb.push_back(mk(2000, 1, 1, 0, 1, 0));
        for (int i = 1; i <= 240; i++) begin
            step(1);
            if (sec_pulse === 1'b1) begin
                n++;
                if (i != last + TD) bad++;
                last = i;
            end
        end
        run_en = 1'b0;
        checks++;
        if (n != 60) $display("FAIL free_pulse_count: got %0d want 60", n); else passes++;
        checks++;
        if (bad != 0) $display("FAIL free_pulse_spacing: got %0d bad intervals want 0", bad); else passes++;
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL free_240: got %h want %h", now_t(), exp_t); else passes++;
    endtask

    task automatic test_day_roll();
        int n;
        set_time(2000, 1, 1, 23, 59, 59);
        sb.push_back(mk(2000, 1, 2, 0, 0, 0));
        do_tick(n);
        checks++;
        if (n != TD) $display("FAIL day_roll_latency: got %0d want %0d", n, TD); else passes++;
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL day_roll: got %h want %h", now_t(), exp_t); else passes++;
    endtask

    task automatic test_leap();
        int yr[3]  = '{2000, 2100, 2024};
        int dd[3]  = '{28, 28, 29};
        int emo[3] = '{2, 3, 3};
        int edd[3] = '{29, 1, 1};
        bit lp[3]  = '{1'b1, 1'b0, 1'b1};
        int n;
        for (int i = 0; i < 3; i++) begin
            set_time(yr[i], 2, dd[i], 23, 59, 59);
            sb.push_back(mk(yr[i], emo[i], edd[i], 0, 0, 0));
            do_tick(n);
            exp_t = sb.pop_front(); checks++;
            if (now_t() !== exp_t) $display("FAIL leap_roll_%0d: got %h want %h", yr[i], now_t(), exp_t); else passes++;
            checks++;
            if (leap !== lp[i]) $display("FAIL leap_flag_%0d: got %b want %b", yr[i], leap, lp[i]); else passes++;
        end
    endtask

    task automatic test_clamp();
        set_time(2023, 1, 31, 0, 0, 0);
        sb.push_back(mk(2023, 2, 28, 0, 0, 0));
        pulse(3'd4, 1'b1, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL clamp_2023: got %h want %h", now_t(), exp_t); else passes++;
        set_time(2024, 1, 31, 0, 0, 0);
        sb.push_back(mk(2024, 2, 29, 0, 0, 0));
        pulse(3'd4, 1'b1, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL clamp_2024: got %h want %h", now_t(), exp_t); else passes++;
        sb.push_back(mk(2024, 2, 1, 0, 0, 0));
        pulse(3'd3, 1'b1, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL day_inc_wrap: got %h want %h", now_t(), exp_t); else passes++;
        sb.push_back(mk(2024, 2, 29, 0, 0, 0));
        pulse(3'd3, 1'b0, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL day_dec_wrap: got %h want %h", now_t(), exp_t); else passes++;
        sb.push_back(mk(2025, 2, 28, 0, 0, 0));
        pulse(3'd5, 1'b1, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL clamp_year_edit: got %h want %h", now_t(), exp_t); else passes++;
    endtask

    task automatic test_year_wrap();
        int n;
        set_time(9999, 12, 31, 23, 59, 59);
        sb.push_back(mk(0, 1, 1, 0, 0, 0));
        do_tick(n);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL year_wrap_tick: got %h want %h", now_t(), exp_t); else passes++;
        checks++;
        if (leap !== 1'b1) $display("FAIL leap_year0: got %b want 1", leap); else passes++;
        set_mode = 1'b1;
        sb.push_back(mk(9999, 1, 1, 0, 0, 0));
        pulse(3'd5, 1'b0, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL year_dec_wrap: got %h want %h", now_t(), exp_t); else passes++;
    endtask

    task automatic test_alarm();
        int n, a0;
        alarm_hour = 5'd7; alarm_minute = 6'd30; alarm_en = 1'b1;
        set_time(2000, 1, 1, 7, 29, 59);
        a0 = alarm_cnt;
        do_tick(n);
        checks++;
        if (alarm_hit !== 1'b1) $display("FAIL alarm_on_tick: got %b want 1", alarm_hit); else passes++;
        step(2);
        checks++;
        if (alarm_cnt - a0 != 1) $display("FAIL alarm_one_cycle: got %0d want 1", alarm_cnt - a0); else passes++;
        alarm_en = 1'b0;
        set_time(2000, 1, 1, 7, 29, 59);
        a0 = alarm_cnt;
        do_tick(n);
        step(2);
        checks++;
        if (alarm_cnt - a0 != 0) $display("FAIL alarm_disabled: got %0d want 0", alarm_cnt - a0); else passes++;
        alarm_en = 1'b1;
        set_time(2000, 1, 1, 7, 29, 0);
        a0 = alarm_cnt;
        sb.push_back(mk(2000, 1, 1, 7, 30, 0));
        pulse(3'd1, 1'b1, 1);
        step(3);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL alarm_manual_time: got %h want %h", now_t(), exp_t); else passes++;
        checks++;
        if (alarm_cnt - a0 != 0) $display("FAIL alarm_manual_edit: got %0d want 0", alarm_cnt - a0); else passes++;
        alarm_en = 1'b0;
    endtask

    task automatic test_ignored_events();
        set_time(2000, 1, 1, 0, 0, 5);
        sb.push_back(mk(2000, 1, 1, 0, 0, 5));
        sel = 3'd0; inc = 1'b1; dec = 1'b1; step(1); inc = 1'b0; dec = 1'b0;
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL inc_dec_both: got %h want %h", now_t(), exp_t); else passes++;
        sb.push_back(mk(2000, 1, 1, 0, 0, 5));
        pulse(3'd6, 1'b1, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL sel6_inc: got %h want %h", now_t(), exp_t); else passes++;
        set_mode = 1'b0; run_en = 1'b0;
        sb.push_back(mk(2000, 1, 1, 0, 0, 5));
        pulse(3'd0, 1'b1, 1);
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL inc_outside_set: got %h want %h", now_t(), exp_t); else passes++;
    endtask

    task automatic test_set_exit_pause_reset();
        int n, seen;
        set_mode = 1'b1; step(2);
        set_mode = 1'b0; run_en = 1'b1;
        run_to_pulse(n);
        checks++;
        if (n != TD) $display("FAIL set_exit_latency: got %0d want %0d", n, TD); else passes++;
        step(2);
        run_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (sec_pulse === 1'b1) seen++;
        end
        run_en = 1'b1;
        run_to_pulse(n);
        checks++;
        if (seen != 0 || n != 2) $display("FAIL pause_stretch: got %0d paused pulses, %0d edges want 0, 2", seen, n); else passes++;
        sb.push_back(mk(2000, 1, 1, 0, 0, 7));
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL pause_time: got %h want %h", now_t(), exp_t); else passes++;
        step(3);
        rst = 1'b1;
        sb.push_back(mk(2000, 1, 1, 0, 0, 0));
        step(1);
        rst = 1'b0;
        exp_t = sb.pop_front(); checks++;
        if (now_t() !== exp_t) $display("FAIL rst_on_tick_time: got %h want %h", now_t(), exp_t); else passes++;
        checks++;
        if (sec_pulse !== 1'b0) $display("FAIL rst_on_tick_pulse: got %b want 0", sec_pulse); else passes++;
        run_to_pulse(n);
        checks++;
        if (n != TD) $display("FAIL rst_presc_restart: got %0d want %0d", n, TD); else passes++;
        run_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_day_roll();
        test_leap();
        test_clamp();
        test_year_wrap();
        test_alarm();
        test_ignored_events();
        test_set_exit_pause_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
